// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Define MULDIV_FAST_MUL_EN to compute all multiplies in a single cycle.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            start,
  input  logic [5:0]      aluControl,
  input  logic [XLEN-1:0] operandA,
  input  logic [XLEN-1:0] operandB,
  output logic [XLEN-1:0] result,
  output logic            busy,
  output logic            done
);

  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2:0]          op_q, op_d;
  logic [XLEN-1:0]     m_q, m_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic                neg_q, neg_d;
  logic                sgn_a_q, sgn_a_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [2:0]          req_op;
  logic                req_is_div;
  logic                signed_a, signed_b;
  logic                a_neg, b_neg;
  logic [XLEN-1:0]     a_mag, b_mag;
  logic                div_by_zero, div_ovf;
  logic                accept;

  assign req_op      = aluControl[2:0];
  assign req_is_div  = req_op[2];
  // Unsigned-A ops: mulhu, divu, remu. mulhsu additionally treats B as unsigned.
  assign signed_a    = !((req_op == 3'b011) || (req_op[2] && req_op[0]));
  assign signed_b    = signed_a && (req_op != 3'b010);
  assign a_neg       = signed_a & operandA[XLEN-1];
  assign b_neg       = signed_b & operandB[XLEN-1];
  assign a_mag       = a_neg ? -operandA : operandA;
  assign b_mag       = b_neg ? -operandB : operandB;
  assign div_by_zero = (operandB == '0);
  assign div_ovf     = !req_op[0] && (operandA == {1'b1, {(XLEN-1){1'b0}}}) && (&operandB);
  assign accept      = start && !flush && ((state_q == IDLE) || (state_q == DONE))
                       && (aluControl[5:3] == 3'b010);

  // Multiply step: acc = {partial product, remaining multiplier bits}.
  logic [XLEN:0]       mul_sum;
  logic [2*XLEN-1:0]   mul_next;
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]}
                    + (acc_q[0] ? {1'b0, m_q} : {(XLEN+1){1'b0}});
  assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

  // Divide step: acc = {partial remainder, dividend shifting into quotient}.
  logic [XLEN:0]       div_shift, div_diff;
  logic                div_ge;
  logic [2*XLEN-1:0]   div_next;
  assign div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, m_q};
  assign div_ge    = !div_diff[XLEN];
  assign div_next  = {(div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]),
                      acc_q[XLEN-2:0], div_ge};

  logic [2*XLEN-1:0]   prod;
  logic [XLEN-1:0]     quo_mag, rem_mag, quo, rem, fix_result;
  assign prod       = neg_q ? -acc_q : acc_q;
  assign quo_mag    = acc_q[XLEN-1:0];
  assign rem_mag    = acc_q[2*XLEN-1:XLEN];
  assign quo        = neg_q ? -quo_mag : quo_mag;
  assign rem        = sgn_a_q ? -rem_mag : rem_mag;
  assign fix_result = op_q[2] ? (op_q[1] ? rem : quo)
                              : ((op_q == 3'b000) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0]   fast_prod;
  assign fast_prod = {{XLEN{a_neg}}, operandA} * {{XLEN{b_neg}}, operandB};
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    m_d      = m_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    sgn_a_d  = sgn_a_q;
    result_d = result_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            op_d    = req_op;
            neg_d   = a_neg ^ b_neg;
            sgn_a_d = a_neg;
            if (req_is_div && div_by_zero) begin
              result_d = req_op[1] ? operandA : {XLEN{1'b1}};
              state_d  = DONE;
            end else if (req_is_div && div_ovf) begin
              result_d = req_op[1] ? {XLEN{1'b0}} : operandA;
              state_d  = DONE;
            end
`ifdef MULDIV_FAST_MUL_EN
            else if (!req_is_div) begin
              result_d = (req_op == 3'b000) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
              state_d  = DONE;
            end
`endif
            else begin
              state_d = RUN;
              cnt_d   = CW'(XLEN);
              m_d     = req_is_div ? b_mag : a_mag;
              acc_d   = {{XLEN{1'b0}}, (req_is_div ? a_mag : b_mag)};
            end
          end else if (state_q == DONE) begin
            state_d = IDLE;
          end
        end
        RUN: begin
          acc_d = op_q[2] ? div_next : mul_next;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = FIX;
        end
        FIX: begin
          result_d = fix_result;
          state_d  = DONE;
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d == RUN) || (state_d == FIX);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      m_q      <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      sgn_a_q  <= 1'b0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      m_q      <= m_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      sgn_a_q  <= sgn_a_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign result = result_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed plan items plus random ops vs. an arithmetic model.
module tb_muldiv_unit;

  localparam int XLEN = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  localparam int MLAT = FAST ? 1 : XLEN + 2;
  localparam int DLAT = XLEN + 2;

  localparam logic [5:0] MUL    = 6'b010000;
  localparam logic [5:0] MULH   = 6'b010001;
  localparam logic [5:0] MULHSU = 6'b010010;
  localparam logic [5:0] MULHU  = 6'b010011;
  localparam logic [5:0] DIV    = 6'b010100;
  localparam logic [5:0] DIVU   = 6'b010101;
  localparam logic [5:0] REM    = 6'b010110;
  localparam logic [5:0] REMU   = 6'b010111;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            start = 1'b0;
  logic [5:0]      aluControl = '0;
  logic [XLEN-1:0] operandA = '0;
  logic [XLEN-1:0] operandB = '0;
  logic [XLEN-1:0] result;
  logic            busy;
  logic            done;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] last_res = '0;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .start(start),
    .aluControl(aluControl), .operandA(operandA), .operandB(operandB),
    .result(result), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout observed=hang expected=finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // RV32M results straight from 64-bit integer arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    p  = '0;
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
    if (!op[2] && FAST) return 1;
    return XLEN + 2;
  endfunction

  // Called on a falling edge; that cycle is cycle 0. Returns on the falling edge of the done cycle.
  task automatic run_op(input string tag, input logic [5:0] ctrl, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                        input int pulse_at);
    int done_cyc;
    int busy_cnt;
    done_cyc = 0;
    busy_cnt = 0;
    start = 1'b1; aluControl = ctrl; operandA = a; operandB = b;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      start = (c == pulse_at);
      if (c == pulse_at) begin
        operandA = $urandom;
        operandB = $urandom | 32'h1;
      end
      if (busy) busy_cnt++;
      if (done) begin
        done_cyc = c;
        break;
      end
    end
    start = 1'b0;
    chk({tag, "_done_cycle"}, done_cyc, exp_lat);
    chk({tag, "_busy_cycles"}, busy_cnt, (exp_lat == 1) ? 0 : XLEN + 1);
    chk({tag, "_result"}, result, exp);
    last_res = exp;
  endtask

  task automatic settle(input string tag);
    @(negedge clk);
    chk({tag, "_done_drop"}, 32'(done), 32'd0);
  endtask

  // Drive a request that must not be accepted and watch for 40 cycles.
  task automatic no_accept(input string tag, input logic [5:0] ctrl, input logic fl);
    int saw_busy;
    int saw_done;
    saw_busy = 0;
    saw_done = 0;
    start = 1'b1; flush = fl; aluControl = ctrl; operandA = 32'd9; operandB = 32'd3;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      if (busy) saw_busy++;
      if (done) saw_done++;
    end
    chk({tag, "_busy"}, saw_busy, 0);
    chk({tag, "_done"}, saw_done, 0);
    chk({tag, "_result"}, result, last_res);
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    int          saw_done;

    #1;
    chk("reset_result", result, 32'h0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Multiply directed cases
    run_op("mul_7x6", MUL, 32'd7, 32'd6, 32'h0000_002A, MLAT, 0);
    settle("mul_7x6");
    run_op("mulh_min", MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MLAT, 0);
    run_op("mulhsu_ff", MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MLAT, 0);
    run_op("mulhu_ff", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MLAT, 0);
    run_op("mul_ff", MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, MLAT, 0);
    settle("mul_ff");

    // Divide directed cases, chained back-to-back from each DONE cycle
    run_op("div_m7_2", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, DLAT, 0);
    run_op("rem_m7_2", REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, DLAT, 0);
    run_op("divu_big", DIVU, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, DLAT, 0);
    run_op("remu_big", REMU, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, DLAT, 0);
    settle("remu_big");

    // Divide by zero and signed overflow shortcuts
    run_op("div_by0", DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);
    settle("div_by0");
    run_op("divu_by0", DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);
    settle("divu_by0");
    run_op("rem_by0", REM, 32'd5, 32'd0, 32'h0000_0005, 1, 0);
    settle("rem_by0");
    run_op("remu_by0", REMU, 32'd5, 32'd0, 32'h0000_0005, 1, 0);
    settle("remu_by0");
    run_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
    settle("div_ovf");
    run_op("rem_ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, 0);
    settle("rem_ovf");

    // Requests that must be ignored
    no_accept("bad_code_lo", 6'b000010, 1'b0);
    no_accept("bad_code_hi", 6'b011000, 1'b0);
    no_accept("flush_start", DIV, 1'b1);

    // Start pulse in cycle 5 of a running divide is ignored
    run_op("div_100_7", DIV, 32'd100, 32'd7, 32'h0000_000E, DLAT, 5);
    settle("div_100_7");

    // Flush in cycle 10
    start = 1'b1; aluControl = DIV; operandA = 32'd1000; operandB = 32'd3;
    @(negedge clk);
    start = 1'b0;
    for (int c = 2; c <= 10; c++) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy_c11", 32'(busy), 32'd0);
    saw_done = 0;
    for (int c = 0; c < 40; c++) begin
      if (done) saw_done++;
      @(negedge clk);
    end
    chk("flush_no_done", saw_done, 0);
    chk("flush_result_kept", result, last_res);

    // Asynchronous reset in cycle 20 of a divide
    start = 1'b1; aluControl = DIV; operandA = 32'd200; operandB = 32'd9;
    @(negedge clk);
    start = 1'b0;
    for (int c = 2; c <= 20; c++) @(negedge clk);
    chk("rst_mid_busy_before", 32'(busy), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_result", result, 32'h0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    last_res = '0;
    saw_done = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) saw_done++;
    end
    chk("rst_mid_no_done", saw_done, 0);

    // Random operations against the arithmetic model, sometimes chained back-to-back
    for (int i = 0; i < 30; i++) begin
      rop = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: ra = $urandom;
        1: ra = 32'h8000_0000;
        2: ra = 32'hFFFF_FFFF;
        default: ra = 32'($urandom_range(0, 20));
      endcase
      case ($urandom_range(0, 4))
        0: rb = $urandom;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'h0;
        3: rb = 32'h8000_0000;
        default: rb = 32'($urandom_range(1, 20));
      endcase
      run_op("rand", {3'b010, rop}, ra, rb, ref_result(rop, ra, rb), ref_lat(rop, ra, rb), 0);
      if ($urandom_range(0, 1) == 1) settle("rand");
    end
    settle("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit downstream of ALU control; consumes 6-bit control codes 010000–010111 and the two execute-stage operands.
- Produces one XLEN result per accepted op; `busy` drives the pipeline stall.
- Single-cycle ALU ops bypass this block entirely.

Parameters:
- XLEN, 32, operand/result width; iteration count = XLEN.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset: asynchronous assert, active-low.
- flush  input  1  synchronous abort of any in-flight op.
- start  input  1  request; sampled in IDLE or DONE only.
- aluControl  input  6  op code: 010000 mul, 010001 mulh, 010010 mulhsu, 010011 mulhu, 010100 div, 010101 divu, 010110 rem, 010111 remu.
- operandA  input  XLEN  rs1 value.
- operandB  input  XLEN  rs2 value.
- result  output  XLEN  registered result; held until the next accepted op.
- busy  output  1  high while in RUN or FIX.
- done  output  1  one-cycle pulse; result valid in the same cycle.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; result=0; busy=0; done=0; counter and internal registers 0.
- States: IDLE, RUN, FIX, DONE.
- Accept condition: start=1, flush=0, state is IDLE or DONE, and aluControl[5:3]==010. Opcode, operands and operand signs are latched.
  - Codes outside the accept range are ignored: no state change, no done.
  - start during RUN/FIX is ignored; operands are not re-sampled.
- Latency: cycle 0 = accept cycle.
  - Normal op: RUN for XLEN cycles, then FIX for 1 cycle. busy=1 in cycles 1..XLEN+1; done=1 in cycle XLEN+2 (cycle 34 at XLEN=32); then IDLE.
  - Accept in DONE gives back-to-back ops; done drops the next cycle.
- Multiply:
  - Operands are converted to magnitudes per signedness: mul/mulh signed×signed; mulhsu signed A × unsigned B; mulhu unsigned.
  - Radix-2 shift-add into a 2·XLEN accumulator, one bit per RUN cycle.
  - FIX negates the product if the operand signs differ.
  - Output: mul → low XLEN bits; mulh/mulhsu/mulhu → high XLEN bits.
- Divide:
  - Restoring, one quotient bit per RUN cycle, on magnitudes (div/rem signed; divu/remu unsigned).
  - FIX sign rules: quotient negated if signs differ; remainder takes the dividend's sign.
- Special cases skip RUN/FIX and go IDLE→DONE, so done=1 in cycle 1 and busy stays 0:
  - Divisor 0: div/divu → all ones; rem/remu → operandA.
  - Signed overflow (operandA=100…0, operandB=all ones): div → operandA; rem → 0.
- Flush:
  - Any state → IDLE on the next edge; done not asserted; result keeps its previous value.
  - Flush and start in the same cycle: flush wins, op not accepted.
- Reset mid-operation: immediate return to reset values; no done.
- Counter: $clog2(XLEN)+1 bits; counts XLEN down to 0; RUN→FIX when it reaches 1 at the edge.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined:
  - All four multiply codes compute in one cycle with a full 2·XLEN product (signed/unsigned extension per op).
  - IDLE→DONE directly: done in cycle 1, busy never asserted.
  - Divides are unchanged.
- Undefined: the iterative multiply described above; no `*` operator is synthesized.

Test Plan:
1. mul 7×6 at cycle 0 → busy high cycles 1–33, done cycle 34 only, result 0x0000002A. With MULDIV_FAST_MUL_EN: done cycle 1, busy never high.
2. mulh 0x80000000×0x80000000 → 0x40000000. mulhsu 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF. mulhu 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. mul 0xFFFFFFFF×0xFFFFFFFF → 0x00000001.
3. div −7/2 → 0xFFFFFFFD; rem −7%2 → 0xFFFFFFFF; divu 0xFFFFFFF9/2 → 0x7FFFFFFC; remu → 0x00000001. All with done in cycle 34.
4. Divisor 0 with operandA=5: div and divu → 0xFFFFFFFF; rem and remu → 0x00000005. done in cycle 1, busy stays 0.
5. Overflow 0x80000000/0xFFFFFFFF: div → 0x80000000, rem → 0x00000000, done in cycle 1. Start with aluControl=000010 → no busy, no done.
6. Robustness:
   - Start div 100/7; pulse start (new operands) in cycle 5 → ignored, result 0x0000000E in cycle 34.
   - flush in cycle 10 → IDLE cycle 11, no done.
   - rst_n low in cycle 20 → outputs 0 immediately.
   - Accept a new op in the DONE cycle → its done lands 34 cycles later.
